conv_window_sequencer: RTL and testbench

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

---
 rtl/conv_window_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Steps one 3x3 convolution window through PORT_COUNT multiplier lanes, one kernel row per pass.
// Define CONV_WAIT_TIMEOUT_EN to abort a stuck WAIT/FINAL with a one-cycle error pulse.
module conv_window_sequencer #(
  parameter int unsigned BIT_LENGTH = 16,
  parameter int unsigned PORT_COUNT = 3
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             cStart,
  input  logic                             fifoEmpty,
  input  logic [BIT_LENGTH-1:0]            fifoData,
  output logic                             fifoRd,
  input  logic                             kernelWe,
  input  logic [3:0]                       kernelAddr,
  input  logic [BIT_LENGTH-1:0]            kernelData,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplierOut,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicandOut,
  output logic [PORT_COUNT-1:0]            mStart,
  input  logic [PORT_COUNT-1:0]            mReady,
  output logic                             finalAdd,
  input  logic                             finalReady,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned Taps = PORT_COUNT * PORT_COUNT;
  localparam int unsigned IdxW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PORT_COUNT - 1);
  localparam logic [3:0] LastAddr = 4'(Taps - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StIssue, StWait, StAccum, StFinal, StDone
  } state_e;

  state_e                           state_q, state_d;
  logic [IdxW-1:0]                  row_q, row_d, col_q, col_d;
  logic [PORT_COUNT-1:0]            mask_q, mask_d;
  logic [BIT_LENGTH-1:0]            pixel_q [PORT_COUNT];
  logic [BIT_LENGTH-1:0]            pixel_d [PORT_COUNT];
  logic [BIT_LENGTH-1:0]            kernel_q [Taps];
  logic [BIT_LENGTH-1:0]            kernel_d [Taps];
  logic [PORT_COUNT*BIT_LENGTH-1:0] mult_q, mult_d, mcand_q, mcand_d;
  logic                             mask_full;
  logic                             timeout;

  // A ready pulse coincident with ISSUE or the final WAIT cycle still completes the row.
  assign mask_full = &(mask_q | mReady);

`ifdef CONV_WAIT_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout = (cnt_q == 8'd254);
  assign cnt_d   = ((state_q == StWait) || (state_q == StFinal)) ? cnt_q + 8'd1 : 8'd0;
  assign err_d   = timeout && ((state_q == StWait) || (state_q == StFinal)) &&
                   (state_d == StIdle);
  assign error   = err_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      row_q   <= '0;
      col_q   <= '0;
      mask_q  <= '0;
      mult_q  <= '0;
      mcand_q <= '0;
      for (int i = 0; i < PORT_COUNT; i++) pixel_q[i] <= '0;
      for (int i = 0; i < Taps; i++) kernel_q[i] <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      mask_q   <= mask_d;
      mult_q   <= mult_d;
      mcand_q  <= mcand_d;
      pixel_q  <= pixel_d;
      kernel_q <= kernel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    mask_d   = mask_q;
    mult_d   = mult_q;
    mcand_d  = mcand_q;
    pixel_d  = pixel_q;
    kernel_d = kernel_q;

    if (kernelWe && (state_q == StIdle) && (kernelAddr <= LastAddr)) begin
      kernel_d[kernelAddr] = kernelData;
    end

    unique case (state_q)
      StIdle: begin
        if (cStart) begin
          state_d = StLoad;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StLoad: begin
        if (!fifoEmpty) begin
          pixel_d[col_q] = fifoData;
          if (col_q == LastIdx) begin
            state_d = StIssue;
            col_d   = '0;
            // Lane buses are loaded here so they are valid throughout ISSUE and then held.
            for (int c = 0; c < PORT_COUNT; c++) begin
              mult_d[c*BIT_LENGTH +: BIT_LENGTH]  = (c == PORT_COUNT - 1) ? fifoData : pixel_q[c];
              mcand_d[c*BIT_LENGTH +: BIT_LENGTH] = kernel_q[4'(int'(row_q) * PORT_COUNT + c)];
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StIssue: begin
        mask_d  = mReady;
        state_d = StWait;
      end
      StWait: begin
        mask_d = mask_q | mReady;
        if (mask_full) begin
          if (row_q == LastIdx) begin
            state_d = StAccum;
          end else begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = StLoad;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StAccum: state_d = StFinal;
      StFinal: begin
        if (finalReady) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    fifoRd   = !Rst && (state_q == StLoad) && !fifoEmpty;
    mStart   = {PORT_COUNT{!Rst && (state_q == StIssue)}};
    finalAdd = !Rst && (state_q == StAccum);
    done     = !Rst && (state_q == StDone);
  end

  assign multiplierOut   = mult_q;
  assign multiplicandOut = mcand_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: FIFO, multiplier and accumulator responders
// plus a lane scoreboard filled when a window is queued and drained on each mStart.
module tb_conv_window_sequencer;
  localparam int BL = 16;
  localparam int PC = 3;

  logic           Clk = 1'b0;
  logic           Rst, cStart, fifoEmpty, fifoRd, kernelWe, finalAdd, finalReady;
  logic           busy, done, error;
  logic [3:0]     kernelAddr;
  logic [BL-1:0]  fifoData, kernelData;
  logic [PC*BL-1:0] multiplierOut, multiplicandOut;
  logic [PC-1:0]  mStart, mReady;

  int errors = 0;
  int checks = 0;

  logic [BL-1:0]    fifo_mem[$];
  logic [PC*BL-1:0] exp_mul[$], exp_mcd[$];
  logic [BL-1:0]    kmodel[9];
  logic [BL-1:0]    pix[9];
  int rd_ptr = 0, exp_ptr = 0, pops = 0, stall_at = -1, stall_cnt = 0;
  int lane_dly[PC];
  int rdy_cnt[PC];
  bit hold_ready = 0, pend_pop = 0, fa_pend = 0;
  int cyc = 0, mstart_cnt = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int bad_rd = 0, start_cyc = 0;

  conv_window_sequencer #(.BIT_LENGTH(BL), .PORT_COUNT(PC)) dut (
    .Clk(Clk), .Rst(Rst), .cStart(cStart), .fifoEmpty(fifoEmpty), .fifoData(fifoData),
    .fifoRd(fifoRd), .kernelWe(kernelWe), .kernelAddr(kernelAddr), .kernelData(kernelData),
    .multiplierOut(multiplierOut), .multiplicandOut(multiplicandOut), .mStart(mStart),
    .mReady(mReady), .finalAdd(finalAdd), .finalReady(finalReady), .busy(busy), .done(done),
    .error(error)
  );

  always #5 Clk = ~Clk;

  // Environment: FWFT FIFO, per-lane multiplier latency, final-add responder, lane monitor.
  initial begin
    mReady = '0; finalReady = 1'b0; fifoEmpty = 1'b1; fifoData = '0;
    for (int l = 0; l < PC; l++) rdy_cnt[l] = 0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Rst) begin
        rd_ptr = fifo_mem.size(); exp_ptr = exp_mul.size();
        pend_pop = 0; fa_pend = 0; stall_cnt = 0;
        for (int l = 0; l < PC; l++) rdy_cnt[l] = 0;
        mReady = '0; finalReady = 1'b0;
      end else begin
        if (pend_pop) begin
          rd_ptr++; pops++;
          if (pops == stall_at) stall_cnt = 5;
        end
        if (mStart !== '0) begin
          mstart_cnt++;
          checks++;
          if (mStart !== '1 || fifoRd !== 1'b0) begin
            errors++;
            $display("FAIL mstart_shape: got mStart=%b fifoRd=%b want 111/0", mStart, fifoRd);
          end
          checks++;
          if (exp_ptr >= exp_mul.size()) begin
            errors++;
            $display("FAIL lanes_unexpected: got mStart with empty scoreboard want none");
          end else begin
            if (multiplierOut !== exp_mul[exp_ptr] || multiplicandOut !== exp_mcd[exp_ptr]) begin
              errors++;
              $display("FAIL lanes: got mul=%h mcd=%h want mul=%h mcd=%h", multiplierOut,
                       multiplicandOut, exp_mul[exp_ptr], exp_mcd[exp_ptr]);
            end
            exp_ptr++;
          end
        end
        for (int l = 0; l < PC; l++) begin
          mReady[l] = 1'b0;
          if (rdy_cnt[l] > 0) begin
            rdy_cnt[l]--;
            if (rdy_cnt[l] == 0) mReady[l] = 1'b1;
          end
          if (mStart[l] && !hold_ready) rdy_cnt[l] = lane_dly[l];
        end
        finalReady = fa_pend;
        fa_pend = finalAdd;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
      end
      fifoEmpty = (rd_ptr >= fifo_mem.size()) || (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      fifoData = (rd_ptr < fifo_mem.size()) ? fifo_mem[rd_ptr] : '0;
      #1;
      pend_pop = fifoRd;
      if (fifoRd && fifoEmpty) bad_rd++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic push_window();
    logic [PC*BL-1:0] m, k;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < PC; c++) begin
        m[c*BL +: BL] = pix[r*3+c];
        k[c*BL +: BL] = kmodel[r*3+c];
        fifo_mem.push_back(pix[r*3+c]);
      end
      exp_mul.push_back(m);
      exp_mcd.push_back(k);
    end
  endtask

  task automatic start_window();
    @(negedge Clk); #2;
    cStart = 1'b1; start_cyc = cyc;
    @(negedge Clk); #2;
    cStart = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, output bit ok);
    for (int i = 0; i < bound && done_cnt == base; i++) begin
      @(negedge Clk); #2;
    end
    ok = (done_cnt != base);
  endtask

  task automatic write_kernel(input int addr, input logic [BL-1:0] data);
    @(negedge Clk); #2;
    kernelWe = 1'b1; kernelAddr = 4'(addr); kernelData = data;
    @(negedge Clk); #2;
    kernelWe = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if ({fifoRd, mStart, finalAdd, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0", {fifoRd, mStart, finalAdd, done, error});
    end
    checks++;
    if ({multiplierOut, multiplicandOut} !== '0) begin
      errors++;
      $display("FAIL reset_lanes: got %h want 0", {multiplierOut, multiplicandOut});
    end
    Rst = 1'b0;
    @(negedge Clk); #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  // Runs a queued window and checks completion, latency and the mStart pulse count.
  task automatic run_and_check(input string name, input int want_lat);
    int b_done, b_ms;
    bit ok;
    b_done = done_cnt; b_ms = mstart_cnt;
    start_window();
    wait_done(b_done, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_done: got no done want done", name);
    end else begin
      checks++;
      if (done_cyc - start_cyc != want_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d want %0d", name, done_cyc - start_cyc, want_lat);
      end
    end
    @(negedge Clk); #2;
    checks++;
    if (mstart_cnt - b_ms != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_mstarts: got %0d busy=%b want 3 busy=0", name, mstart_cnt - b_ms, busy);
    end
  endtask

  task automatic test_kernel_reset();
    for (int i = 0; i < 9; i++) pix[i] = BL'(i + 1);
    push_window();
    run_and_check("kernel_reset", 18);
  endtask

  task automatic test_basic();
    for (int a = 0; a < 9; a++) begin
      write_kernel(a, 16'd1);
      kmodel[a] = 16'd1;
    end
    for (int i = 0; i < 9; i++) pix[i] = BL'(i + 1);
    push_window();
    run_and_check("basic", 18);
  endtask

  task automatic test_pattern();
    for (int a = 0; a < 9; a++) begin
      write_kernel(a, BL'(16'h0101 * (a + 1)));
      kmodel[a] = BL'(16'h0101 * (a + 1));
    end
    for (int i = 0; i < 9; i++) pix[i] = BL'($urandom);
    push_window();
    run_and_check("pattern", 18);
  endtask

  task automatic test_fifo_stall();
    int b_bad;
    b_bad = bad_rd;
    stall_at = pops + 2;
    for (int i = 0; i < 9; i++) pix[i] = BL'(16'hA000 + i);
    push_window();
    run_and_check("fifo_stall", 23);
    stall_at = -1;
    checks++;
    if (bad_rd != b_bad) begin
      errors++; $display("FAIL stall_rd: got %0d pops while empty want 0", bad_rd - b_bad);
    end
  endtask

  task automatic test_lane_skew();
    lane_dly[0] = 1; lane_dly[1] = 1; lane_dly[2] = 5;
    for (int i = 0; i < 9; i++) pix[i] = BL'(16'h0B00 + i);
    push_window();
    run_and_check("lane_skew", 30);
    lane_dly[2] = 1;
  endtask

  task automatic test_kernel_protect();
    int b_done;
    bit ok;
    b_done = done_cnt;
    for (int i = 0; i < 9; i++) pix[i] = BL'(16'h0C00 + i);
    push_window();
    start_window();
    write_kernel(4, 16'h0055);
    wait_done(b_done, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL protect_done1: got no done want done"); end
    write_kernel(12, 16'h0077);
    push_window();
    run_and_check("protect", 18);
  endtask

  task automatic test_cstart_ignored();
    int b_done;
    bit ok;
    b_done = done_cnt;
    for (int i = 0; i < 9; i++) pix[i] = BL'(16'h0D00 + i);
    push_window();
    start_window();
    repeat (5) @(negedge Clk);
    #2; cStart = 1'b1;
    @(negedge Clk); #2; cStart = 1'b0;
    wait_done(b_done, 200, ok);
    checks++;
    if (!ok || done_cyc - start_cyc != 18) begin
      errors++;
      $display("FAIL ignore_latency: got ok=%0b lat=%0d want 1/18", ok, done_cyc - start_cyc);
    end
    repeat (25) @(negedge Clk);
    #2;
    checks++;
    if (busy !== 1'b0 || done_cnt != b_done + 1) begin
      errors++;
      $display("FAIL ignore_queue: got busy=%b dones=%0d want 0/1", busy, done_cnt - b_done);
    end
  endtask

  task automatic test_reset_mid();
    int b_ms;
    b_ms = mstart_cnt;
    for (int l = 0; l < PC; l++) lane_dly[l] = 10;
    for (int i = 0; i < 9; i++) pix[i] = BL'(16'h0E00 + i);
    push_window();
    start_window();
    for (int i = 0; i < 100 && mstart_cnt < b_ms + 2; i++) begin
      @(negedge Clk); #2;
    end
    checks++;
    if (mstart_cnt != b_ms + 2) begin
      errors++; $display("FAIL rstmid_reach: got %0d mStarts want 2", mstart_cnt - b_ms);
    end
    @(negedge Clk); #2;
    Rst = 1'b1;
    @(negedge Clk); #2;
    Rst = 1'b0;
    for (int l = 0; l < PC; l++) lane_dly[l] = 1;
    checks++;
    if (busy !== 1'b0 || {fifoRd, mStart, finalAdd, done, error} !== '0 ||
        {multiplierOut, multiplicandOut} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got busy=%b strobes=%b lanes=%h want all 0", busy,
               {fifoRd, mStart, finalAdd, done, error}, {multiplierOut, multiplicandOut});
    end
    for (int i = 0; i < 9; i++) kmodel[i] = '0;
    for (int i = 0; i < 9; i++) pix[i] = BL'(16'h0F00 + i);
    push_window();
    run_and_check("rstmid_clean", 18);
  endtask

`ifdef CONV_WAIT_TIMEOUT_EN
  task automatic test_timeout();
    int b_done, b_err;
    b_done = done_cnt; b_err = err_cnt;
    hold_ready = 1'b1;
    for (int i = 0; i < 9; i++) pix[i] = BL'(i);
    push_window();
    start_window();
    for (int i = 0; i < 400 && err_cnt == b_err; i++) begin
      @(negedge Clk); #2;
    end
    checks++;
    if (err_cnt != b_err + 1 || err_cyc - start_cyc != 260) begin
      errors++;
      $display("FAIL timeout_error: got errs=%0d at %0d want 1 at 260", err_cnt - b_err,
               err_cyc - start_cyc);
    end
    repeat (5) @(negedge Clk);
    #2;
    checks++;
    if (busy !== 1'b0 || done_cnt != b_done) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b dones=%0d want 0/0", busy, done_cnt - b_done);
    end
    hold_ready = 1'b0;
    Rst = 1'b1;
    @(negedge Clk); #2;
    Rst = 1'b0;
  endtask
`endif

  initial begin
    Rst = 1'b1; cStart = 1'b0; kernelWe = 1'b0; kernelAddr = '0; kernelData = '0;
    for (int l = 0; l < PC; l++) lane_dly[l] = 1;
    for (int i = 0; i < 9; i++) kmodel[i] = '0;
    test_reset();
    test_kernel_reset();
    test_basic();
    test_pattern();
    test_fifo_stall();
    test_lane_skew();
    test_kernel_protect();
    test_cstart_ignored();
    test_reset_mid();
`ifdef CONV_WAIT_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (err_cnt != 0) begin errors++; $display("FAIL error_tied: got %0d pulses want 0", err_cnt); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
